// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM encodings, bubble word,
// PC increment and word-alignment helper.
package fetch_stage_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR        = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with hold > load > sequential priority; every load is
// forced onto a word boundary and the increment wraps modulo 2^32.
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_load,
  input  logic [31:0] i_load_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + PC_INCR;

  always_comb begin
    w_pc_next = r_pc;
    if (i_hold) begin
      w_pc_next = r_pc;
    end else if (i_load) begin
      w_pc_next = i_load_pc;
    end else begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= pc_align(w_pc_next);
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID pipeline register, RUN/HALTED control
// and statistics counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_IR   = NOP_IR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_id,
  output logic [31:0] pc1_id,
  output logic [31:0] ir_id,
  output logic        valid_id,
  output logic [31:0] cycle_cnt,
  output logic [31:0] redir_cnt,
  output logic [31:0] stall_cnt,
  output logic        halted
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic        w_run;
  logic        w_halt_take;
  logic        w_redirect_take;
  logic        w_seq_take;
  logic        w_pc_hold;
  logic        w_halted;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;

  logic [31:0] r_pc_id;
  logic [31:0] r_pc1_id;
  logic [31:0] r_ir_id;
  logic        r_valid_id;
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_redir_cnt;
  logic [31:0] r_stall_cnt;

  // Halt outranks stall, which outranks redirect.
  assign w_run           = (r_state == ST_RUN);
  assign w_halt_take     = w_run && halt;
  assign w_redirect_take = w_run && !halt && !stall && redirect;
  assign w_seq_take      = w_run && !halt && !stall && !redirect;
  assign w_pc_hold       = !w_run || halt || stall;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (w_pc_hold),
    .i_load     (redirect),
    .i_load_pc  (redirect_pc),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_halted     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt) begin
          w_state_next = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // IF/ID register: a halt edge or an accepted redirect squashes the fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_id    <= 32'h0;
      r_pc1_id   <= 32'h0;
      r_ir_id    <= NOP_IR;
      r_valid_id <= 1'b0;
    end else if (w_halt_take || w_redirect_take) begin
      r_pc_id    <= 32'h0;
      r_pc1_id   <= 32'h0;
      r_ir_id    <= NOP_IR;
      r_valid_id <= 1'b0;
    end else if (w_seq_take) begin
      r_pc_id    <= w_pc;
      r_pc1_id   <= w_pc_plus4;
      r_ir_id    <= imem_data;
      r_valid_id <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt <= 32'h0;
      r_redir_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else if (w_run) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_redirect_take) begin
        r_redir_cnt <= r_redir_cnt + 32'd1;
      end
    end
  end

  assign imem_addr = w_pc;
  assign pc_id     = r_pc_id;
  assign pc1_id    = r_pc1_id;
  assign ir_id     = r_ir_id;
  assign valid_id  = r_valid_id;
  assign cycle_cnt = r_cycle_cnt;
  assign redir_cnt = r_redir_cnt;
  assign stall_cnt = r_stall_cnt;
  assign halted    = w_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven edge pushes the model's
// expected architectural state, popped and compared one cycle later.
module tb_fetch_stage;

  localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] T_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_id;
    logic [31:0] pc1_id;
    logic [31:0] ir_id;
    logic        valid;
    logic [31:0] cyc;
    logic [31:0] redir;
    logic [31:0] stl;
    logic        halted;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_id;
  logic [31:0] pc1_id;
  logic [31:0] ir_id;
  logic        valid_id;
  logic [31:0] cycle_cnt;
  logic [31:0] redir_cnt;
  logic [31:0] stall_cnt;
  logic        halted;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t got;
  obs_t expv;

  logic [31:0] m_pc, m_pc_id, m_pc1, m_ir, m_cyc, m_redir, m_stl;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (T_RESET_PC),
    .NOP_IR   (T_NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc_id       (pc_id),
    .pc1_id      (pc1_id),
    .ir_id       (ir_id),
    .valid_id    (valid_id),
    .cycle_cnt   (cycle_cnt),
    .redir_cnt   (redir_cnt),
    .stall_cnt   (stall_cnt),
    .halted      (halted)
  );

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign imem_data = imem_fn(imem_addr);

  function automatic obs_t observe();
    obs_t o;
    o.pc = imem_addr; o.pc_id = pc_id; o.pc1_id = pc1_id; o.ir_id = ir_id;
    o.valid = valid_id; o.cyc = cycle_cnt; o.redir = redir_cnt;
    o.stl = stall_cnt; o.halted = halted;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.pc = m_pc; o.pc_id = m_pc_id; o.pc1_id = m_pc1; o.ir_id = m_ir;
    o.valid = m_valid; o.cyc = m_cyc; o.redir = m_redir;
    o.stl = m_stl; o.halted = m_halted;
    return o;
  endfunction

  // Drive one edge's inputs, advance the reference model, push its result.
  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic h);
    logic [31:0] old_pc;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; halt = h;
    old_pc = m_pc;
    if (r) begin
      m_pc = T_RESET_PC; m_pc_id = 0; m_pc1 = 0; m_ir = T_NOP; m_valid = 0;
      m_cyc = 0; m_redir = 0; m_stl = 0; m_halted = 0;
    end else if (!m_halted) begin
      m_cyc = m_cyc + 1;
      if (s) m_stl = m_stl + 1;
      if (h) begin
        m_halted = 1; m_pc_id = 0; m_pc1 = 0; m_ir = T_NOP; m_valid = 0;
      end else if (s) begin
        m_pc = old_pc;
      end else if (rd) begin
        m_pc = {rpc[31:2], 2'b00};
        m_pc_id = 0; m_pc1 = 0; m_ir = T_NOP; m_valid = 0;
        m_redir = m_redir + 1;
      end else begin
        m_pc_id = old_pc; m_pc1 = old_pc + 32'd4; m_ir = imem_fn(old_pc);
        m_valid = 1; m_pc = old_pc + 32'd4;
      end
    end
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    $display("txn rst=%0b stall=%0b redir=%0b rpc=%h halt=%0b -> pc=%h ir_id=%h valid=%0b",
             r, s, rd, rpc, h, imem_addr, ir_id, valid_id);
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 32'h55, 1);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL reset: got %h required %h", got, expv);
    end
  endtask

  task automatic test_sequential();
    drive(1, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      got = observe(); expv = exp_q.pop_front(); n_vec++;
      if (got !== expv) begin
        n_err++; $display("FAIL seq%0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0, 0);
    void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 0); void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 0); void'(exp_q.pop_front());
    drive(0, 0, 1, 32'h40, 0);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL redirect: got %h required %h", got, expv);
    end
    drive(0, 0, 0, 0, 0);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv || ir_id !== imem_fn(32'h40)) begin
      n_err++; $display("FAIL redirect_fetch: got %h required %h", got, expv);
    end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 0, 0); void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 32'h80, 0);
      got = observe(); expv = exp_q.pop_front(); n_vec++;
      if (got !== expv) begin
        n_err++; $display("FAIL stall%0d: got %h required %h", i, got, expv);
      end
    end
    drive(1, 1, 0, 0, 0);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL reset_mid_stall: got %h required %h", got, expv);
    end
  endtask

  task automatic test_wrap_align();
    drive(0, 0, 1, 32'hFFFF_FFFC, 0);
    void'(exp_q.pop_front());
    drive(0, 0, 0, 0, 0);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL wrap: got %h required %h", got, expv);
    end
    drive(0, 0, 1, 32'h43, 0);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL align: got %h required %h", got, expv);
    end
  endtask

  task automatic test_halt();
    drive(0, 0, 0, 0, 0); void'(exp_q.pop_front());
    drive(0, 1, 1, 32'h100, 1);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL halt_edge: got %h required %h", got, expv);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      got = observe(); expv = exp_q.pop_front(); n_vec++;
      if (got !== expv) begin
        n_err++; $display("FAIL halted%0d: got %h required %h", i, got, expv);
      end
    end
    drive(1, 0, 0, 0, 1);
    got = observe(); expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin
      n_err++; $display("FAIL halt_reset: got %h required %h", got, expv);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 0, 0, 0); void'(exp_q.pop_front());
    for (int i = 0; i < 40; i++) begin
      drive(0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            $urandom_range(0, 255), 0);
      got = observe(); expv = exp_q.pop_front(); n_vec++;
      if (got !== expv) begin
        n_err++; $display("FAIL b2b%0d: got %h required %h", i, got, expv);
      end
    end
  endtask

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
    m_pc = 0; m_pc_id = 0; m_pc1 = 0; m_ir = 0; m_valid = 0;
    m_cyc = 0; m_redir = 0; m_stl = 0; m_halted = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_wrap_align();
    test_halt();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_IR, default 32'h0000_0000, the instruction word inserted as a bubble.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port stall  input  1  load-use hazard from ID; holds PC and IF/ID.
REQ-006 SHALL have port redirect  input  1  taken control transfer resolved in ID (jmp OR correct_b of next-PC logic).
REQ-007 SHALL have port redirect_pc  input  32  target from next-PC logic (NPC_out).
REQ-008 SHALL have port halt  input  1  syscall-halt from WB.
REQ-009 SHALL have port imem_addr  output  32  byte address to instruction memory, equal to current PC.
REQ-010 SHALL have port imem_data  input  32  instruction word, combinationally valid for imem_addr.
REQ-011 SHALL have ports pc_id, pc1_id, ir_id  output  32 each  IF/ID register: PC, PC+4, instruction.
REQ-012 SHALL have port valid_id  output  1  IF/ID holds a real instruction (0 = bubble).
REQ-013 SHALL have ports cycle_cnt, redir_cnt, stall_cnt  output  32 each  statistics counters.
REQ-014 SHALL have port halted  output  1  FSM is in HALTED.

Function
REQ-015 SHALL keep a two-state FSM: RUN, HALTED; RUN -> HALTED when halt=1 at a rising edge; HALTED exits only via rst.
REQ-016 In RUN, per edge, priority SHALL be: stall > redirect > sequential.
REQ-017 stall=1: PC, pc_id, pc1_id, ir_id, valid_id SHALL hold; redirect ignored that cycle.
REQ-018 redirect=1, stall=0: PC SHALL load redirect_pc; IF/ID SHALL load ir_id=NOP_IR, valid_id=0, pc_id/pc1_id=0 (flush of wrong-path fetch).
REQ-019 Otherwise: PC SHALL load PC+4; IF/ID SHALL load pc_id=PC, pc1_id=PC+4, ir_id=imem_data, valid_id=1.
REQ-020 PC+4 SHALL be 32-bit modulo (32'hFFFF_FFFC -> 32'h0000_0000), no error.
REQ-021 PC bits[1:0] SHALL be forced to 0 on every load, including redirect.
REQ-022 Fetch-to-ID latency SHALL be exactly one cycle; a redirect costs exactly one bubble.
REQ-023 halt=1 together with stall or redirect: halt wins; PC and IF/ID take the halt-edge behaviour of REQ-024.
REQ-024 On entering HALTED, IF/ID SHALL load a bubble; in HALTED PC, IF/ID and all counters SHALL freeze; halted=1.
REQ-025 cycle_cnt SHALL increment every edge in RUN; redir_cnt on every accepted redirect (REQ-018); stall_cnt on every edge with stall=1 in RUN; all wrap modulo 2^32.

Reset
REQ-026 rst=1 at an edge SHALL set PC=RESET_PC, pc_id=pc1_id=0, ir_id=NOP_IR, valid_id=0, counters=0, FSM=RUN, halted=0, overriding all other inputs, including mid-stall and in HALTED.
REQ-027 The first instruction after rst deasserts SHALL appear in ir_id one edge later with pc_id=RESET_PC.

Structure
REQ-028 FSM state encodings, NOP_IR and the PC increment constant 4 SHALL live in the shared CPU package.
REQ-029 The PC register with its priority mux SHALL be one sub-module, pc_reg; IF/ID register and counters stay in fetch_stage.

Verification
REQ-030 Reset then 3 free cycles, imem[0/4/8]=A/B/C -> ir_id sequence A,B,C; pc_id 0,4,8; cycle_cnt=3.
REQ-031 redirect=1, redirect_pc=32'h40 at PC=8 -> next PC=32'h40, valid_id=0, redir_cnt=1; following edge ir_id=imem[32'h40].
REQ-032 stall=1 for 2 cycles with redirect=1 -> PC and IF/ID unchanged, redir_cnt=0, stall_cnt=2.
REQ-033 PC=32'hFFFF_FFFC, no stall/redirect -> PC=0, pc1_id=0, pc_id=32'hFFFF_FFFC.
REQ-034 halt=1 -> halted=1, valid_id=0, counters and PC frozen for 10 cycles; rst -> PC=RESET_PC, halted=0.
REQ-035 redirect_pc=32'h43 -> PC=32'h40.
